// File: rtl/ws2812_chain_driver.sv
// WS2812 daisy-chain driver: per-LED GRB colour store, exact-cycle bit serialiser,
// latch period and optional continuous refresh.
module ws2812_chain_driver #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned T0H_CYC      = 20,
  parameter int unsigned T1H_CYC      = 40,
  parameter int unsigned TBIT_CYC     = 62,
  parameter int unsigned RESET_CYC    = 2500,
  parameter bit          AUTO_REFRESH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_color,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              led_data_out
);

  localparam int unsigned CNT_MAX = (TBIT_CYC > RESET_CYC) ? TBIT_CYC : RESET_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(TBIT_CYC - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0]  HI0        = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0]  HI1        = CNT_W'(T1H_CYC);
  localparam logic [ADDR_W-1:0] LED_LAST   = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

  state_t            state, state_n;
  logic [23:0]       color [NUM_LEDS];
  logic [23:0]       shreg;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [CNT_W-1:0]  cyc_inc;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] led_cnt;
  logic [ADDR_W-1:0] led_inc;
  logic [23:0]       next_word;
  logic              led_n;
  logic              bit_end, word_end, latch_end;

  assign cyc_inc   = cyc_cnt + CNT_W'(1);
  assign led_inc   = led_cnt + ADDR_W'(1);
  assign bit_end   = (state == S_BIT) && (cyc_cnt == BIT_LAST);
  assign word_end  = bit_end && (bit_cnt == 5'd23);
  assign latch_end = (state == S_LATCH) && (cyc_cnt == LATCH_LAST);
  assign next_word = (led_cnt == LED_LAST) ? '0 : color[led_inc];

  assign busy       = (state != S_IDLE);
  assign frame_done = latch_end;

  // Colour store; the loader reads the pre-edge value, so a same-cycle write is seen next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) color[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
      color[wr_addr] <= wr_color;
    end
  end

  // The line level is computed one cycle ahead so led_data_out comes straight from a flop.
  always_comb begin
    state_n = state;
    led_n   = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  begin
        state_n = S_BIT;
        led_n   = 1'b1;
      end
      S_BIT:   begin
        if (word_end && (led_cnt == LED_LAST)) state_n = S_LATCH;
        else if (bit_end)                      led_n   = 1'b1;
        else                                   led_n   = cyc_inc < (shreg[23] ? HI1 : HI0);
      end
      S_LATCH: if (latch_end) state_n = AUTO_REFRESH ? S_LOAD : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      led_data_out <= 1'b0;
      shreg        <= '0;
      cyc_cnt      <= '0;
      bit_cnt      <= '0;
      led_cnt      <= '0;
    end else begin
      state        <= state_n;
      led_data_out <= led_n;
      case (state)
        S_LOAD: begin
          shreg   <= color[0];
          cyc_cnt <= '0;
          bit_cnt <= '0;
          led_cnt <= '0;
        end
        S_BIT: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (word_end) begin
              bit_cnt <= '0;
              led_cnt <= led_inc;
              shreg   <= next_word;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[22:0], 1'b0};
            end
          end else begin
            cyc_cnt <= cyc_inc;
          end
        end
        S_LATCH: cyc_cnt <= cyc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed/randomised bench for ws2812_chain_driver (3 LEDs), with a pulse-width
// reference built from the colour model and a second auto-refresh instance.
module tb_ws2812_chain_driver;
  localparam int NL    = 3;
  localparam int FRAME = 1 + NL * 24 * 62 + 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, start;
  logic [1:0]  wr_addr;
  logic [23:0] wr_color;
  logic        busy, frame_done, led;
  logic        ar_rst_n, ar_start, ar_busy, ar_fd, ar_led;

  ws2812_chain_driver #(.NUM_LEDS(3), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_color(wr_color),
    .start(start), .busy(busy), .frame_done(frame_done), .led_data_out(led)
  );

  ws2812_chain_driver #(.NUM_LEDS(3), .ADDR_W(2), .AUTO_REFRESH(1'b1)) dut_ar (
    .clk(clk), .rst_n(ar_rst_n), .wr_en(1'b0), .wr_addr(2'd0), .wr_color(24'd0),
    .start(ar_start), .busy(ar_busy), .frame_done(ar_fd), .led_data_out(ar_led)
  );

  int passed = 0;
  int total  = 0;

  logic [23:0] mcol [NL];
  int          exp_q[$];

  int hw_q[$], lw_q[$];
  int hi_run = 0, lo_run = 0, busy_cnt = 0, fd_cnt = 0;

  always @(negedge clk) begin
    if (led === 1'b1) begin
      if (lo_run > 0 && hw_q.size() > 0) lw_q.push_back(lo_run);
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) hw_q.push_back(hi_run);
      hi_run = 0;
      lo_run++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  int cyc = 0;
  int ar_fd_q[$], ar_gap_q[$];
  int ar_busy_low = 0, ar_last_fd = 0;
  bit ar_on = 1'b0, ar_pend = 1'b0, ar_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ar_on) begin
      if (ar_busy !== 1'b1) ar_busy_low++;
      if (ar_fd === 1'b1) begin
        ar_fd_q.push_back(cyc);
        ar_pend    = 1'b1;
        ar_last_fd = cyc;
      end else if (ar_pend && ar_led === 1'b1 && !ar_prev) begin
        ar_gap_q.push_back(cyc - ar_last_fd);
        ar_pend = 1'b0;
      end
    end
    ar_prev = (ar_led === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [23:0] c);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_color = c;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < NL) mcol[a] = c;
  endtask

  task automatic expect_led(input logic [23:0] c);
    for (int b = 23; b >= 0; b--) exp_q.push_back(c[b] ? 40 : 20);
  endtask

  task automatic begin_frame(input string tag);
    @(posedge clk);
    hw_q.delete(); lw_q.delete(); exp_q.delete();
    hi_run = 0; lo_run = 0; busy_cnt = 0; fd_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_led_e0"}, led, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_led_e1"}, led, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, busy, 0);
  endtask

  task automatic check_frame(input string tag);
    int bad;
    check({tag, "_npulses"}, hw_q.size(), exp_q.size());
    check({tag, "_busy_cycles"}, busy_cnt, FRAME);
    check({tag, "_frame_done"}, fd_cnt, 1);
    if (hw_q.size() == exp_q.size() && exp_q.size() > 0) begin
      bad = exp_q.size() - 1;
      for (int k = exp_q.size() - 1; k >= 0; k--) if (hw_q[k] != exp_q[k]) bad = k;
      check($sformatf("%s_width%0d", tag, bad), hw_q[bad], exp_q[bad]);
    end
  endtask

  initial begin
    logic [23:0] old0, rc;
    int n, bad;
    rst_n = 1'b0; ar_rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_color = '0;
    start = 1'b0; ar_start = 1'b0;
    for (int i = 0; i < NL; i++) mcol[i] = '0;

    #3;
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; ar_rst_n = 1'b1;

    @(negedge clk);
    ar_start = 1'b1;
    @(posedge clk); #1;
    ar_start = 1'b0;
    ar_on = 1'b1;

    // 1: all-zero colours
    begin_frame("t1");
    wait_idle("t1", FRAME + 50);
    for (int i = 0; i < NL; i++) expect_led(mcol[i]);
    check_frame("t1");
    check("t1_nlows", lw_q.size(), 71);
    if (lw_q.size() > 0) begin
      bad = lw_q.size() - 1;
      for (int k = lw_q.size() - 1; k >= 0; k--) if (lw_q[k] != 42) bad = k;
      check($sformatf("t1_low%0d", bad), lw_q[bad], 42);
    end

    // 2: directed colours plus a random LED1 value
    rc = 24'($urandom);
    do_write(2'd0, 24'hA50000);
    do_write(2'd1, rc);
    do_write(2'd2, 24'h0000FF);
    begin_frame("t2");
    wait_idle("t2", FRAME + 50);
    for (int i = 0; i < NL; i++) expect_led(mcol[i]);
    check_frame("t2");

    // 3: out-of-range write, starts while busy, start on the busy-falling edge
    do_write(2'd3, 24'hFFFFFF);
    begin_frame("t3");
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(60, 110)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (frame_done !== 1'b1 && n < FRAME) begin
      @(negedge clk);
      n++;
    end
    check("t3_fd_seen", frame_done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_start_at_end_ignored", busy, 0);
    repeat (20) @(negedge clk);
    wait_idle("t3", 10);
    for (int i = 0; i < NL; i++) expect_led(mcol[i]);
    check_frame("t3");

    // 4: writes during LED0's bits
    old0 = mcol[0];
    begin_frame("t4");
    repeat ($urandom_range(100, 1200)) @(negedge clk);
    do_write(2'd2, 24'hFFFFFF);
    do_write(2'd0, 24'h000000);
    wait_idle("t4", FRAME + 50);
    expect_led(old0);
    expect_led(mcol[1]);
    expect_led(mcol[2]);
    check_frame("t4");
    begin_frame("t4b");
    wait_idle("t4b", FRAME + 50);
    for (int i = 0; i < NL; i++) expect_led(mcol[i]);
    check_frame("t4b");

    // 5: reset mid-frame
    begin_frame("t5");
    repeat (1000) @(negedge clk);
    n = 0;
    while (led !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_led_high_before_rst", led, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_led", led, 0);
    check("t5_rst_busy", busy, 0);
    for (int i = 0; i < NL; i++) mcol[i] = '0;
    repeat (3) @(negedge clk);
    check("t5_no_frame_done", fd_cnt, 0);
    rst_n = 1'b1;
    begin_frame("t5b");
    wait_idle("t5b", FRAME + 50);
    for (int i = 0; i < NL; i++) expect_led(mcol[i]);
    check_frame("t5b");

    // 6: auto-refresh instance, observed in the background throughout
    check("t6_nframes_ge3", ar_fd_q.size() >= 3, 1);
    for (int k = 1; k < ar_fd_q.size(); k++)
      check($sformatf("t6_period%0d", k), ar_fd_q[k] - ar_fd_q[k-1], FRAME);
    for (int k = 0; k < ar_gap_q.size(); k++)
      check($sformatf("t6_gap%0d", k), ar_gap_q[k], 2);
    check("t6_busy_never_low", ar_busy_low, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
